uart_rx: RTL and testbench

UART receiver for the command-processor datapath. It deserialises 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) arriving on the serial input. Each frame is sampled at mid-bit using a clock-cycle bit timer, so no oversampling clock is needed. Each accepted byte is presented as a one-cycle strobe to the command parser; it is the receive-side counterpart of the existing UART transmitter and uses the same baud parameters.

---
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised input, mid-bit sampling driven by a
// clock-cycle bit timer, one-cycle strobes for good bytes and framing errors.
module uart_rx #(
    parameter int BAUDRATE = 300000,
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RX,
    output logic [7:0] RX_data,
    output logic       RX_valid,
    output logic       frame_error,
    output logic       q_busy
);

    localparam int CYCLES = CLK_FREQ / BAUDRATE;
    localparam int HALF   = CYCLES / 2;
    localparam int TW     = $clog2(CYCLES);

    localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);
    localparam logic [TW-1:0] CYC_M1  = TW'(CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic          rx_meta_q;
    logic          rx_s_q;
    logic          rx_d_q;
    logic          fall_s;
    state_t        state_q,   state_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q,   shift_d;
    logic [7:0]    data_q,    data_d;
    logic          valid_q,   valid_d;
    logic          ferr_q,    ferr_d;

    // Synchroniser plus delay stage; idle-high reset avoids a false start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

    assign fall_s = ~rx_s_q & rx_d_q;

    // Receiver state, timer, shift register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state logic: timer clears at every sample point, counts otherwise
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (fall_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (timer_q == HALF_M1) begin
                    timer_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (timer_q == CYC_M1) begin
                    timer_d   = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (timer_q == CYC_M1) begin
                    timer_d = '0;
                    state_d = IDLE;
                    // Only a high stop bit commits the byte
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign RX_data     = data_q;
    assign RX_valid    = valid_q;
    assign frame_error = ferr_q;
    assign q_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a default-baud instance and a 115200-baud
// instance driven by a bit-level transmitter model and scored by event monitors.
module tb_uart_rx;

    localparam int C0   = 50000000 / 300000;
    localparam int H0   = C0 / 2;
    localparam int LAT0 = H0 + 9 * C0;
    localparam int C1   = 50000000 / 115200;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_fast;
    logic [7:0] rx_data,  rx_data_f;
    logic       rx_valid, rx_valid_f;
    logic       ferr,     ferr_f;
    logic       busy,     busy_f;

    int checks = 0;
    int errors = 0;

    uart_rx dut (
        .clk(clk), .reset(reset), .RX(rx),
        .RX_data(rx_data), .RX_valid(rx_valid),
        .frame_error(ferr), .q_busy(busy)
    );

    uart_rx #(.BAUDRATE(115200), .CLK_FREQ(50000000)) dut_fast (
        .clk(clk), .reset(reset), .RX(rx_fast),
        .RX_data(rx_data_f), .RX_valid(rx_valid_f),
        .frame_error(ferr_f), .q_busy(busy_f)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    int  valid_cnt = 0, ferr_cnt = 0, both_cnt = 0, busy_cnt = 0;
    int  busy_rise_cyc = 0, valid_cyc = 0, valid_cyc_prev = 0;
    bit  busy_prev = 1'b0;
    int  f_valid_cnt = 0, f_ferr_cnt = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (busy && !busy_prev) busy_rise_cyc = cyc;
        if (busy) busy_cnt = busy_cnt + 1;
        if (rx_valid) begin
            valid_cnt      = valid_cnt + 1;
            valid_cyc_prev = valid_cyc;
            valid_cyc      = cyc;
        end
        if (ferr) ferr_cnt = ferr_cnt + 1;
        if (rx_valid && ferr) both_cnt = both_cnt + 1;
        busy_prev = busy;
        if (rx_valid_f) f_valid_cnt = f_valid_cnt + 1;
        if (ferr_f) f_ferr_cnt = f_ferr_cnt + 1;
    end

    logic [7:0] exp_data   = 8'h00;
    logic [7:0] exp_data_f = 8'h00;

    task automatic set_line(input bit fast, input logic v);
        if (fast) rx_fast = v;
        else      rx = v;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb,
                              input int period, input bit fast);
        logic [9:0] bits;
        bits = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            set_line(fast, bits[i]);
            repeat (period) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // One frame on the default instance, scored against the frame's own bits
    task automatic frame_check(input string name, input logic [7:0] b,
                               input logic stopb);
        int v0, f0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(b, stopb, C0, 1'b0);
        idle(4);
        if (stopb) exp_data = b;
        checks++;
        if ((valid_cnt - v0) !== (stopb ? 1 : 0)) begin
            errors++;
            $display("FAIL %s valid_count: got %0d expected %0d", name, valid_cnt - v0, stopb ? 1 : 0);
        end
        checks++;
        if ((ferr_cnt - f0) !== (stopb ? 0 : 1)) begin
            errors++;
            $display("FAIL %s ferr_count: got %0d expected %0d", name, ferr_cnt - f0, stopb ? 0 : 1);
        end
        checks++;
        if (rx_data !== exp_data) begin
            errors++;
            $display("FAIL %s rx_data: got %02h expected %02h", name, rx_data, exp_data);
        end
        if (stopb) begin
            checks++;
            if ((valid_cyc - busy_rise_cyc) !== LAT0) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", name, valid_cyc - busy_rise_cyc, LAT0);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after: got %0b expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx = 1'b1;
        rx_fast = 1'b1;
        idle(5);
        checks++;
        if ({rx_data, rx_valid, ferr, busy} !== 11'h000 || {rx_data_f, rx_valid_f, ferr_f, busy_f} !== 11'h000) begin
            errors++;
            $display("FAIL reset_values: got %02h/%0b%0b%0b expected 00/000", rx_data, rx_valid, ferr, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        idle(20);
    endtask

    task automatic test_single();
        frame_check("a5", 8'hA5, 1'b1);
        idle(50);
    endtask

    task automatic test_back_to_back();
        int v0, f0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h00, 1'b1, C0, 1'b0);
        idle(0);
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL b2b_first_data: got %02h expected 00", rx_data);
        end
        send_frame(8'hFF, 1'b1, C0, 1'b0);
        idle(4);
        exp_data = 8'hFF;
        checks++;
        if ((valid_cnt - v0) !== 2 || (ferr_cnt - f0) !== 0) begin
            errors++;
            $display("FAIL b2b_counts: got valid %0d ferr %0d expected 2 0", valid_cnt - v0, ferr_cnt - f0);
        end
        checks++;
        if ((valid_cyc - valid_cyc_prev) !== 10 * C0) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d expected %0d", valid_cyc - valid_cyc_prev, 10 * C0);
        end
        checks++;
        if (rx_data !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_second_data: got %02h expected ff", rx_data);
        end
        idle(50);
    endtask

    task automatic test_glitch();
        int v0, f0, b0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        b0 = busy_cnt;
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        idle(300);
        checks++;
        if ((valid_cnt - v0) !== 0 || (ferr_cnt - f0) !== 0) begin
            errors++;
            $display("FAIL glitch_strobes: got valid %0d ferr %0d expected 0 0", valid_cnt - v0, ferr_cnt - f0);
        end
        checks++;
        if ((busy_cnt - b0) !== H0) begin
            errors++;
            $display("FAIL glitch_busy_len: got %0d expected %0d", busy_cnt - b0, H0);
        end
    endtask

    task automatic test_frame_error();
        int b0, v0;
        b0 = busy_cnt;
        v0 = valid_cnt;
        frame_check("3c_ferr", 8'h3C, 1'b0);
        idle(3000);
        checks++;
        if ((busy_cnt - b0) !== LAT0 || (valid_cnt - v0) !== 0) begin
            errors++;
            $display("FAIL ferr_no_retrigger: got busy %0d valid %0d expected %0d 0", busy_cnt - b0, valid_cnt - v0, LAT0);
        end
        rx = 1'b1;
        idle(200);
        frame_check("42_after", 8'h42, 1'b1);
        idle(50);
    endtask

    task automatic test_reset_midframe();
        int v0, f0;
        logic [9:0] bits;
        bits = {1'b1, 8'h99, 1'b0};
        v0 = valid_cnt;
        f0 = ferr_cnt;
        for (int i = 0; i < 5; i++) begin
            rx = bits[i];
            repeat (C0) @(negedge clk);
        end
        rx = bits[5];
        repeat (H0) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        exp_data = 8'h00;
        checks++;
        if ({rx_data, rx_valid, ferr, busy} !== 11'h000) begin
            errors++;
            $display("FAIL midframe_reset: got %02h/%0b%0b%0b expected 00/000", rx_data, rx_valid, ferr, busy);
        end
        rx = 1'b1;
        idle(10);
        @(negedge clk);
        reset = 1'b1;
        idle(2000);
        checks++;
        if ((valid_cnt - v0) !== 0 || (ferr_cnt - f0) !== 0) begin
            errors++;
            $display("FAIL midframe_strobes: got valid %0d ferr %0d expected 0 0", valid_cnt - v0, ferr_cnt - f0);
        end
        frame_check("5a_after_reset", 8'h5A, 1'b1);
        idle(50);
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       s;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) != 0);
            frame_check($sformatf("rand%0d", i), b, s);
            rx = 1'b1;
            idle($urandom_range(3, 200));
        end
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL exclusive_strobes: got %0d expected 0", both_cnt);
        end
    endtask

    task automatic test_fast_baud();
        int periods [3];
        int v0, f0;
        periods[0] = C1;
        periods[1] = (C1 * 103) / 100;
        periods[2] = (C1 * 97) / 100;
        for (int p = 0; p < 3; p++) begin
            v0 = f_valid_cnt;
            f0 = f_ferr_cnt;
            send_frame(8'h81, 1'b1, periods[p], 1'b1);
            idle(4);
            checks++;
            if (rx_data_f !== 8'h81) begin
                errors++;
                $display("FAIL fast_81_p%0d: got %02h expected 81", periods[p], rx_data_f);
            end
            send_frame(8'h7E, 1'b1, periods[p], 1'b1);
            idle(4);
            checks++;
            if (rx_data_f !== 8'h7E) begin
                errors++;
                $display("FAIL fast_7e_p%0d: got %02h expected 7e", periods[p], rx_data_f);
            end
            checks++;
            if ((f_valid_cnt - v0) !== 2 || (f_ferr_cnt - f0) !== 0) begin
                errors++;
                $display("FAIL fast_counts_p%0d: got valid %0d ferr %0d expected 2 0", periods[p], f_valid_cnt - v0, f_ferr_cnt - f0);
            end
            idle(100);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_midframe();
        test_random();
        test_fast_baud();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
